keyseq_sender: RTL and testbench

KEYSEQ_SENDER -- requirements
Module: keyseq_sender

---
 rtl/keyseq_sender.sv | 118 +++++++++++
 tb/tb_keyseq_sender.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/keyseq_sender.sv
// Sends a stored six-digit code to a lock one digit at a time with idle gaps,
// then samples the lock status and tracks the result and a failure counter.
module keyseq_sender (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        code_load,
  input  logic [23:0] code_in,
  input  logic [3:0]  gap,
  input  logic        locked,
  output logic [3:0]  key,
  output logic        key_valid,
  output logic        busy,
  output logic        done,
  output logic        success,
  output logic        load_err,
  output logic [7:0]  fail_cnt
);

  typedef enum logic [2:0] {IDLE, SEND, GAP, CHECK, DONE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  idx_reg;
  logic [3:0]  gap_cnt_reg;
  logic [23:0] code_reg;
  logic        success_reg;
  logic        load_err_reg;
  logic [7:0]  fail_cnt_reg;
  logic [5:0]  digit_ok;
  logic        code_ok;

  // A load is only accepted when every digit is a decimal value.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit_chk
      assign digit_ok[gi] = (code_in[4*gi +: 4] <= 4'd9);
    end
  endgenerate
  assign code_ok = &digit_ok;

  always_comb begin
    state_next = state_reg;
    if (state_reg != IDLE && abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start && !code_load) state_next = SEND;
        SEND:    state_next = GAP;
        GAP:     if (gap_cnt_reg == 4'd0) state_next = (idx_reg == 3'd5) ? CHECK : SEND;
        CHECK:   state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    key       = 4'hF;
    key_valid = 1'b0;
    if (state_reg == SEND) begin
      key_valid = 1'b1;
      case (idx_reg)
        3'd0:    key = code_reg[3:0];
        3'd1:    key = code_reg[7:4];
        3'd2:    key = code_reg[11:8];
        3'd3:    key = code_reg[15:12];
        3'd4:    key = code_reg[19:16];
        default: key = code_reg[23:20];
      endcase
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign success  = success_reg;
  assign load_err = load_err_reg;
  assign fail_cnt = fail_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      idx_reg      <= 3'd0;
      gap_cnt_reg  <= 4'd0;
      code_reg     <= 24'h652533;
      success_reg  <= 1'b0;
      load_err_reg <= 1'b0;
      fail_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      load_err_reg <= 1'b0;
      if (state_reg == IDLE && code_load) begin
        if (code_ok) code_reg <= code_in;
        else         load_err_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: idx_reg <= 3'd0;
        // Gap counter holds the remaining cycles after the current one.
        SEND: gap_cnt_reg <= (gap == 4'd0) ? 4'd0 : gap - 4'd1;
        GAP: begin
          if (gap_cnt_reg != 4'd0)  gap_cnt_reg <= gap_cnt_reg - 4'd1;
          else if (idx_reg != 3'd5) idx_reg <= idx_reg + 3'd1;
        end
        CHECK: begin
          if (!abort) begin
            success_reg <= ~locked;
            if (locked) begin
              if (fail_cnt_reg != 8'd255) fail_cnt_reg <= fail_cnt_reg + 8'd1;
            end else begin
              fail_cnt_reg <= 8'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keyseq_sender.sv
// Scoreboard bench for keyseq_sender: stimulus pushes expected keys/done
// records, a negedge monitor pops and compares whatever the DUT presents.
module tb_keyseq_sender;

  logic        clk = 1'b0;
  logic        reset, start, abort, code_load, locked;
  logic [23:0] code_in;
  logic [3:0]  gap;
  logic [3:0]  key;
  logic        key_valid, busy, done, success, load_err;
  logic [7:0]  fail_cnt;

  typedef struct {
    int         kind;   // 0 = key digit, 1 = done
    logic [7:0] v1;     // key value, or success
    logic [7:0] v2;     // 0, or fail_cnt
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  logic       exp_succ;
  logic [7:0] exp_fail;

  keyseq_sender dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .code_load(code_load), .code_in(code_in), .gap(gap), .locked(locked),
    .key(key), .key_valid(key_valid), .busy(busy), .done(done),
    .success(success), .load_err(load_err), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every key_valid or done cycle must match the head of the queue.
  always @(negedge clk) begin
    if (key_valid === 1'b1 || done === 1'b1) begin
      exp_t e;
      int   kind;
      logic [7:0] v1, v2;
      kind = (done === 1'b1) ? 1 : 0;
      v1   = (kind == 1) ? {7'd0, success} : {4'd0, key};
      v2   = (kind == 1) ? fail_cnt : 8'd0;
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: kind=%0d val=%0h/%0h at cycle %0d, required no output",
                 kind, v1, v2, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != kind || e.v1 !== v1 || e.v2 !== v2 || e.cyc != cyc) begin
          n_fail++;
          $display("FAIL txn: got kind=%0d val=%0h/%0h cycle=%0d, required kind=%0d val=%0h/%0h cycle=%0d",
                   kind, v1, v2, cyc, e.kind, e.v1, e.v2, e.cyc);
        end else begin
          $display("txn ok: kind=%0d val=%0h/%0h cycle=%0d", kind, v1, v2, cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key"},       {28'd0, key}, 32'hF);
    check({tag, "_key_valid"}, {31'd0, key_valid}, 32'd0);
    check({tag, "_busy"},      {31'd0, busy}, 32'd0);
    check({tag, "_done"},      {31'd0, done}, 32'd0);
    check({tag, "_success"},   {31'd0, success}, 32'd0);
    check({tag, "_load_err"},  {31'd0, load_err}, 32'd0);
    check({tag, "_fail_cnt"},  {24'd0, fail_cnt}, 32'd0);
  endtask

  // One full transmission; lock_final is the locked level presented at CHECK.
  task automatic run_seq(input logic [23:0] exp_code, input logic [3:0] g,
                         input logic lock_final, input bit extra);
    int gg, a;
    bit seen;
    gg = (g == 4'd0) ? 1 : int'(g);
    gap = g;
    locked = 1'b1;
    a = cyc + 1;
    for (int k = 0; k < 6; k++)
      exp_q.push_back('{0, {4'd0, exp_code[4*k +: 4]}, 8'd0, a + k * (1 + gg)});
    exp_succ = ~lock_final;
    if (lock_final) exp_fail = (exp_fail == 8'd255) ? 8'd255 : exp_fail + 8'd1;
    else            exp_fail = 8'd0;
    exp_q.push_back('{1, {7'd0, exp_succ}, exp_fail, a + 1 + 6 * (1 + gg)});
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 6 * (1 + gg) + 6 && !seen; i++) begin
      tick();
      if (cyc >= a + 5 * (1 + gg) + 1) locked = lock_final;
      if (extra) begin
        start     = (cyc == a + 2);
        code_load = (cyc == a + 2);
        code_in   = 24'hFFFFFF;
        if (cyc == a + 3) check("load_while_busy_err", {31'd0, load_err}, 32'd0);
      end
      if (done === 1'b1) seen = 1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    start = 1'b0;
    code_load = 1'b0;
    tick();
  endtask

  initial begin
    int a;
    reset = 1'b0; start = 1'b0; abort = 1'b0; code_load = 1'b0;
    code_in = 24'd0; gap = 4'd1; locked = 1'b1;
    exp_succ = 1'b0; exp_fail = 8'd0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b1;
    tick();

    // Default code, gap=1, lock opens after the sixth digit.
    run_seq(24'h652533, 4'd1, 1'b0, 0);
    check("success_after_open", {31'd0, success}, 32'd1);

    // Valid load, gap=0 acts as 1, lock stays shut.
    code_in = 24'h000001; code_load = 1'b1;
    tick();
    code_load = 1'b0;
    check("load_ok_no_err", {31'd0, load_err}, 32'd0);
    run_seq(24'h000001, 4'd0, 1'b1, 0);

    // Invalid load from a fresh reset keeps the default code.
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    exp_succ = 1'b0; exp_fail = 8'd0;
    code_in = 24'h00A000; code_load = 1'b1;
    tick();
    code_load = 1'b0;
    check("bad_load_err", {31'd0, load_err}, 32'd1);
    tick();
    check("bad_load_err_width", {31'd0, load_err}, 32'd0);
    run_seq(24'h652533, 4'd1, 1'b1, 0);

    // Abort in the third gap (gap=3).
    gap = 4'd3; locked = 1'b1;
    a = cyc + 1;
    exp_q.push_back('{0, 8'h3, 8'd0, a});
    exp_q.push_back('{0, 8'h3, 8'd0, a + 4});
    exp_q.push_back('{0, 8'h5, 8'd0, a + 8});
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < a + 9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_key", {28'd0, key}, 32'hF);
    check("abort_key_valid", {31'd0, key_valid}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_fail_cnt", {24'd0, fail_cnt}, {24'd0, exp_fail});
    check("abort_success", {31'd0, success}, {31'd0, exp_succ});
    repeat (20) tick();

    // Saturation of the failure counter, then a clearing success.
    for (int n = 0; n < 256; n++) run_seq(24'h652533, 4'd0, 1'b1, 0);
    check("fail_cnt_saturated", {24'd0, fail_cnt}, 32'd255);
    run_seq(24'h652533, 4'd0, 1'b0, 0);
    check("fail_cnt_cleared", {24'd0, fail_cnt}, 32'd0);

    // start together with code_load: start ignored, code taken.
    code_in = 24'h123456; code_load = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; code_load = 1'b0;
    check("start_with_load_busy", {31'd0, busy}, 32'd0);
    tick();
    check("start_with_load_busy2", {31'd0, busy}, 32'd0);
    run_seq(24'h123456, 4'd2, 1'b1, 1);

    // Reset in the middle of SEND.
    gap = 4'd1; locked = 1'b1;
    a = cyc + 1;
    exp_q.push_back('{0, 8'h6, 8'd0, a});
    start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    tick();
    check_reset_outputs("mid_send_reset");
    reset = 1'b1;
    exp_succ = 1'b0; exp_fail = 8'd0;
    repeat (5) tick();
    check("no_restart_busy", {31'd0, busy}, 32'd0);
    run_seq(24'h652533, 4'd1, 1'b0, 0);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
